semi_auto_ctrl: RTL and testbench

SEMI_AUTO_CTRL -- requirements
Module: semi_auto_ctrl

---
 rtl/drive_pkg.sv | 29 ++
 rtl/semi_auto_ctrl_if.sv | 27 ++
 rtl/edge_pulse.sv | 23 ++
 rtl/semi_auto_ctrl.sv | 96 +++++++++
 tb/tb_semi_auto_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drive_pkg.sv
// Shared state encodings and drive words for the semi-auto and manual-mode controllers.
package drive_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CMD = 3'd1,
    FORWARD  = 3'd2,
    SETTLE   = 3'd3,
    TURN_L   = 3'd4,
    TURN_R   = 3'd5,
    UTURN    = 3'd6
  } state_t;

  // Drive word layout is {right, left, backward, forward}.
  localparam logic [3:0] DRIVE_STOP  = 4'b0000;
  localparam logic [3:0] DRIVE_FWD   = 4'b0001;
  localparam logic [3:0] DRIVE_LEFT  = 4'b0100;
  localparam logic [3:0] DRIVE_RIGHT = 4'b1000;

  function automatic logic [3:0] drive_of(state_t s);
    case (s)
      FORWARD, SETTLE: drive_of = DRIVE_FWD;
      TURN_L, UTURN:   drive_of = DRIVE_LEFT;
      TURN_R:          drive_of = DRIVE_RIGHT;
      default:         drive_of = DRIVE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/semi_auto_ctrl_if.sv
// User buttons, obstacle detectors and drive/status outputs of the semi-auto controller.
interface semi_auto_ctrl_if;
  logic       enable;
  logic       cmd_forward;
  logic       cmd_left;
  logic       cmd_right;
  logic       cmd_back;
  logic       front_detector;
  logic       left_detector;
  logic       right_detector;
  logic       back_detector;
  logic [3:0] moving_state;
  logic       busy;
  logic [2:0] fsm_state;

  modport master (
    output enable, cmd_forward, cmd_left, cmd_right, cmd_back,
    output front_detector, left_detector, right_detector, back_detector,
    input  moving_state, busy, fsm_state
  );

  modport slave (
    input  enable, cmd_forward, cmd_left, cmd_right, cmd_back,
    input  front_detector, left_detector, right_detector, back_detector,
    output moving_state, busy, fsm_state
  );
endinterface

// File: rtl/edge_pulse.sv
// Per-bit rising-edge detector; history resets high so a button held through reset never fires.
module edge_pulse #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] pulse
);

  logic [W-1:0] hist;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      hist  <= '1;
      pulse <= '0;
    end else begin
      hist  <= din;
      pulse <= din & ~hist;
    end
  end

endmodule

// File: rtl/semi_auto_ctrl.sv
// Semi-auto drive sequencer: IDLE off | WAIT_CMD stopped | FORWARD cruise | SETTLE post-turn straight,
// junctions masked | TURN_L/TURN_R 90-degree turn | UTURN 180-degree turn (left drive).
module semi_auto_ctrl
  import drive_pkg::*;
#(
  parameter int TURN_CYCLES   = 90_000_000,
  parameter int SETTLE_CYCLES = 50_000_000
) (
  input  logic             sys_clk,
  input  logic             rst,
  semi_auto_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(2*TURN_CYCLES+1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES-1);
  localparam logic [CNT_W-1:0] UTURN_LOAD  = CNT_W'(2*TURN_CYCLES-1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES-1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       moving_q;
  logic [3:0]       cmd_edge;
  logic             front, left, right, cnt_zero;

  assign front    = bus.front_detector;
  assign left     = bus.left_detector;
  assign right    = bus.right_detector;
  assign cnt_zero = (cnt == '0);

  edge_pulse #(.W(4)) u_edge (
    .sys_clk (sys_clk),
    .rst     (rst),
    .din     ({bus.cmd_back, bus.cmd_right, bus.cmd_left, bus.cmd_forward}),
    .pulse   (cmd_edge)
  );

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      moving_q <= DRIVE_STOP;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      moving_q <= drive_of(state_nx);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE:     if (bus.enable) state_nx = WAIT_CMD;
      WAIT_CMD: begin
        // Corners and dead ends resolve on their own; otherwise only the top-priority press counts.
        if (front && left && right)       state_nx = UTURN;
        else if (front && !left && right) state_nx = TURN_L;
        else if (front && left && !right) state_nx = TURN_R;
        else if (cmd_edge[0]) begin
          if (!front) state_nx = FORWARD;
        end else if (cmd_edge[1]) begin
          if (!left) state_nx = TURN_L;
        end else if (cmd_edge[2]) begin
          if (!right) state_nx = TURN_R;
        end else if (cmd_edge[3]) begin
          state_nx = UTURN;
        end
      end
      FORWARD:  if (front || !left || !right) state_nx = WAIT_CMD;
      SETTLE: begin
        if (front)         state_nx = WAIT_CMD;
        else if (cnt_zero) state_nx = FORWARD;
      end
      TURN_L, TURN_R, UTURN: if (cnt_zero) state_nx = SETTLE;
      default:  state_nx = IDLE;
    endcase

    if (!bus.enable) state_nx = IDLE;

    if (state_nx != state) begin
      case (state_nx)
        TURN_L, TURN_R: cnt_nx = TURN_LOAD;
        UTURN:          cnt_nx = UTURN_LOAD;
        SETTLE:         cnt_nx = SETTLE_LOAD;
        default:        cnt_nx = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_nx = cnt - CNT_W'(1);
    end
  end

  assign bus.moving_state = moving_q;
  assign bus.busy         = (state != IDLE) && (state != WAIT_CMD);
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_semi_auto_ctrl.sv
// Bench for semi_auto_ctrl: directed scenarios plus random stimulus against a cycle reference model.
module tb_semi_auto_ctrl;

  localparam int TURN   = 8;
  localparam int SETTLE = 4;

  localparam int M_IDLE = 0, M_WAIT = 1, M_FWD = 2, M_SETTLE = 3, M_TL = 4, M_TR = 5, M_UT = 6;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  int         m_mode, m_age;
  logic [3:0] m_prev, m_press;

  semi_auto_ctrl_if bus();

  semi_auto_ctrl #(.TURN_CYCLES(TURN), .SETTLE_CYCLES(SETTLE)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [3:0] exp_drive(int m);
    case (m)
      M_FWD, M_SETTLE: exp_drive = 4'b0001;
      M_TL, M_UT:      exp_drive = 4'b0100;
      M_TR:            exp_drive = 4'b1000;
      default:         exp_drive = 4'b0000;
    endcase
  endfunction

  function automatic int duration(int m);
    case (m)
      M_TL, M_TR: duration = TURN;
      M_UT:       duration = 2*TURN;
      M_SETTLE:   duration = SETTLE;
      default:    duration = 0;
    endcase
  endfunction

  function automatic logic [3:0] cmd_vec();
    cmd_vec = {bus.cmd_back, bus.cmd_right, bus.cmd_left, bus.cmd_forward};
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_age   = 0;
    m_prev  = 4'hF;
    m_press = 4'h0;
  endtask

  // Reference behaviour at one rising edge, from the inputs present at that edge.
  task automatic model_edge();
    int nm, pick;
    logic f, l, r;
    if (rst !== 1'b1) begin
      model_reset();
      return;
    end
    f  = bus.front_detector;
    l  = bus.left_detector;
    r  = bus.right_detector;
    nm = m_mode;
    if (!bus.enable) nm = M_IDLE;
    else begin
      case (m_mode)
        M_IDLE: nm = M_WAIT;
        M_WAIT: begin
          if (f && l && r)       nm = M_UT;
          else if (f && (l ^ r)) nm = l ? M_TR : M_TL;
          else begin
            pick = -1;
            for (int i = 3; i >= 0; i--) if (m_press[i]) pick = i;
            case (pick)
              0: if (!f) nm = M_FWD;
              1: if (!l) nm = M_TL;
              2: if (!r) nm = M_TR;
              3: nm = M_UT;
              default: ;
            endcase
          end
        end
        M_FWD:    if (f || !l || !r) nm = M_WAIT;
        M_SETTLE: if (f) nm = M_WAIT; else if (m_age == SETTLE) nm = M_FWD;
        default:  if (m_age == duration(m_mode)) nm = M_SETTLE;
      endcase
    end
    m_age   = (nm != m_mode) ? 1 : m_age + 1;
    m_mode  = nm;
    m_press = cmd_vec() & ~m_prev;
    m_prev  = cmd_vec();
  endtask

  task automatic compare(input string tag);
    checks++;
    assert (bus.moving_state === exp_drive(m_mode)) else begin
      errors++;
      $error("FAIL %s moving_state got %b expected %b", tag, bus.moving_state, exp_drive(m_mode));
    end
    checks++;
    assert (bus.busy === (m_mode >= M_FWD)) else begin
      errors++;
      $error("FAIL %s busy got %b expected %b", tag, bus.busy, (m_mode >= M_FWD));
    end
    checks++;
    assert (bus.fsm_state === 3'(m_mode)) else begin
      errors++;
      $error("FAIL %s fsm_state got %0d expected %0d", tag, bus.fsm_state, m_mode);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag = "cycle");
    @(posedge sys_clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic count_mov(input logic [3:0] mv, output int n);
    n = 0;
    while (bus.moving_state === mv && n < 64) begin
      tick("count_mov");
      n++;
    end
  endtask

  task automatic count_state(input logic [2:0] st, output int n);
    n = 0;
    while (bus.fsm_state === st && n < 64) begin
      tick("count_state");
      n++;
    end
  endtask

  task automatic press(input int idx);
    case (idx)
      0: bus.cmd_forward = 1'b1;
      1: bus.cmd_left    = 1'b1;
      2: bus.cmd_right   = 1'b1;
      default: bus.cmd_back = 1'b1;
    endcase
    tick("press");
    {bus.cmd_back, bus.cmd_right, bus.cmd_left, bus.cmd_forward} = 4'b0000;
    tick("press_resp");
  endtask

  task automatic set_det(input logic f, input logic l, input logic r);
    bus.front_detector = f;
    bus.left_detector  = l;
    bus.right_detector = r;
  endtask

  initial begin
    int n, guard;
    logic [3:0] tog, cv;
    bus.enable = 1'b0;
    {bus.cmd_back, bus.cmd_right, bus.cmd_left, bus.cmd_forward} = 4'b0000;
    set_det(1'b0, 1'b0, 1'b0);
    bus.back_detector = 1'b0;
    model_reset();

    tick("reset");
    tick("reset");
    check_int("reset_fsm", int'(bus.fsm_state), 0);

    rst = 1'b1;
    bus.enable = 1'b1;
    tick("enable");
    check_int("idle_to_wait", int'(bus.fsm_state), M_WAIT);

    // Forward press with nothing around: drive two cycles after the press, then stop at the junction.
    press(0);
    check_int("fwd_latency", int'(bus.moving_state), 1);
    tick("fwd_junction");
    check_int("fwd_open_sides_stop", int'(bus.fsm_state), M_WAIT);

    // Corridor, then corner with only right open.
    set_det(1'b0, 1'b1, 1'b1);
    press(0);
    repeat (3) tick("corridor");
    set_det(1'b1, 1'b1, 1'b0);
    tick("corner_stop");
    check_int("corner_wait", int'(bus.fsm_state), M_WAIT);
    tick("corner_turn");
    set_det(1'b0, 1'b1, 1'b1);
    count_mov(4'b1000, n);
    check_int("turn_r_len", n, TURN);
    count_state(3'd3, n);
    check_int("settle_len", n, SETTLE);
    check_int("settle_to_fwd", int'(bus.fsm_state), M_FWD);

    // Dead end.
    set_det(1'b1, 1'b1, 1'b1);
    tick("dead_end_stop");
    tick("dead_end_uturn");
    set_det(1'b0, 1'b1, 1'b1);
    count_mov(4'b0100, n);
    check_int("uturn_len", n, 2*TURN);
    count_state(3'd3, n);
    check_int("uturn_settle_len", n, SETTLE);

    // Simultaneous left/right presses, then enable dropped in turn cycle 3.
    set_det(1'b0, 1'b0, 1'b0);
    tick("open_junction");
    bus.cmd_left  = 1'b1;
    bus.cmd_right = 1'b1;
    tick("lr_press");
    bus.cmd_left  = 1'b0;
    bus.cmd_right = 1'b0;
    tick("lr_resp");
    check_int("lr_priority", int'(bus.fsm_state), M_TL);
    tick("tl_c2");
    tick("tl_c3");
    bus.enable = 1'b0;
    tick("enable_drop");
    check_int("enable_drop_idle", int'(bus.fsm_state), M_IDLE);
    bus.enable = 1'b1;
    tick("reenable");

    // Blocked-side command ignored; held button must not retrigger once the side opens.
    set_det(1'b0, 1'b1, 1'b0);
    bus.cmd_left = 1'b1;
    repeat (6) tick("blocked_left");
    check_int("blocked_left_wait", int'(bus.fsm_state), M_WAIT);
    set_det(1'b0, 1'b0, 1'b0);
    repeat (4) tick("held_left");
    check_int("held_no_retrigger", int'(bus.fsm_state), M_WAIT);
    bus.cmd_left = 1'b0;
    tick("release");

    // Reset asserted mid-settle must stop drive before any clock edge.
    press(2);
    set_det(1'b0, 1'b1, 1'b1);
    guard = 0;
    while (bus.fsm_state !== 3'd3 && guard < 40) begin
      tick("to_settle");
      guard++;
    end
    check_int("reached_settle", int'(bus.fsm_state), M_SETTLE);
    tick("settle_c2");
    rst = 1'b0;
    model_reset();
    #1;
    check_int("async_rst_mov", int'(bus.moving_state), 0);
    compare("async_rst");
    tick("in_reset");
    rst = 1'b1;
    tick("after_reset");

    // Random phase against the reference model.
    cv = 4'b0000;
    for (int c = 0; c < 5000; c++) begin
      bus.enable = ($urandom_range(199) != 0);
      for (int i = 0; i < 4; i++) tog[i] = ($urandom_range(9) == 0);
      cv = cv ^ tog;
      {bus.cmd_back, bus.cmd_right, bus.cmd_left, bus.cmd_forward} = cv;
      if ($urandom_range(19) == 0) bus.front_detector = ~bus.front_detector;
      if ($urandom_range(19) == 0) bus.left_detector  = ~bus.left_detector;
      if ($urandom_range(19) == 0) bus.right_detector = ~bus.right_detector;
      if ($urandom_range(9) == 0)  bus.back_detector  = ~bus.back_detector;
      if (rst && $urandom_range(299) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        compare("rand_async_rst");
      end else if (!rst && $urandom_range(2) == 0) begin
        rst = 1'b1;
      end
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
